// File: rtl/location_speed_estimator.sv
// Position differentiator with modulo wrap, jump rejection and a
// moving average over the last 2^AVG_SHIFT per-sample deltas.
module location_speed_estimator #(
    parameter int DATA_WIDTH = 16,
    parameter int POS_WIDTH  = 17,
    parameter int SAMPLE_DIV = 1000,
    parameter int AVG_SHIFT  = 2,
    parameter int MAX_DELTA  = 4096
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  speed_estimate_enable_in,
    input  logic [POS_WIDTH-1:0]  location_detection_value_in,
    output logic [DATA_WIDTH-1:0] pmsm_location_speed_value_out,
    output logic                  speed_valid_out,
    output logic                  location_jump_fault_out,
    output logic                  speed_ready_out
);
    localparam int DEPTH = 1 << AVG_SHIFT;
    localparam int SUM_W = POS_WIDTH + AVG_SHIFT;
    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [AVG_SHIFT:0] FULL = (AVG_SHIFT + 1)'(DEPTH);
    localparam logic signed [POS_WIDTH:0] LIM = (POS_WIDTH + 1)'(MAX_DELTA);
    localparam logic signed [SUM_W-1:0] OUT_MAX =
        SUM_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN =
        SUM_W'(-(1 << (DATA_WIDTH - 1)));

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                       state;
    logic [CNT_W-1:0]             cnt;
    logic [POS_WIDTH-1:0]         cur_pos;
    logic [POS_WIDTH-1:0]         prev_pos;
    logic                         s1_vld;
    logic                         s1_prime;
    logic                         s2_vld;
    logic signed [POS_WIDTH-1:0]  delta;
    logic signed [POS_WIDTH-1:0]  win [DEPTH];
    logic [AVG_SHIFT-1:0]         wr_idx;
    logic signed [SUM_W-1:0]      sum;
    logic [AVG_SHIFT:0]           fill;

    logic                         tick;
    logic signed [POS_WIDTH:0]    delta_x;
    logic                         reject;
    logic signed [SUM_W-1:0]      next_sum;
    logic signed [SUM_W-1:0]      avg;
    logic [DATA_WIDTH-1:0]        sat;

    assign tick     = (state != IDLE) && (cnt == TICK_AT);
    assign delta_x  = {delta[POS_WIDTH-1], delta};
    assign reject   = (delta_x > LIM) || (delta_x < -LIM);
    assign next_sum = sum + SUM_W'(delta) - SUM_W'(win[wr_idx]);
    assign avg      = next_sum >>> AVG_SHIFT;
    assign speed_ready_out = (fill == FULL);

    always_comb begin
        sat = avg[DATA_WIDTH-1:0];
        if (avg > OUT_MAX)
            sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (avg < OUT_MIN)
            sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end

    always_ff @(posedge sys_clk or posedge reset_n) begin
        if (reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_pos  <= '0;
            prev_pos <= '0;
            s1_vld   <= 1'b0;
            s1_prime <= 1'b0;
            s2_vld   <= 1'b0;
            delta    <= '0;
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            wr_idx   <= '0;
            sum      <= '0;
            fill     <= '0;
            pmsm_location_speed_value_out <= '0;
            speed_valid_out         <= 1'b0;
            location_jump_fault_out <= 1'b0;
        end else if (!speed_estimate_enable_in) begin
            // Dropping enable flushes the pipeline, so no pulse leaks out.
            state    <= IDLE;
            cnt      <= '0;
            s1_vld   <= 1'b0;
            s1_prime <= 1'b0;
            s2_vld   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            wr_idx   <= '0;
            sum      <= '0;
            fill     <= '0;
            pmsm_location_speed_value_out <= '0;
            speed_valid_out         <= 1'b0;
            location_jump_fault_out <= 1'b0;
        end else begin
            speed_valid_out         <= 1'b0;
            location_jump_fault_out <= 1'b0;
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            case (state)
                IDLE: begin
                    state <= PRIME;
                    cnt   <= '0;
                end
                default: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick && state == PRIME) state <= RUN;
                end
            endcase
            if (tick) begin
                cur_pos  <= location_detection_value_in;
                s1_vld   <= 1'b1;
                s1_prime <= (state == PRIME);
            end
            if (s1_vld) begin
                prev_pos <= cur_pos;
                delta    <= $signed(cur_pos - prev_pos);
                s2_vld   <= !s1_prime;
            end
            if (s2_vld) begin
                if (reject) begin
                    location_jump_fault_out <= 1'b1;
                end else begin
                    win[wr_idx] <= delta;
                    wr_idx      <= wr_idx + 1'b1;
                    sum         <= next_sum;
                    pmsm_location_speed_value_out <= sat;
                    speed_valid_out <= 1'b1;
                    if (fill != FULL) fill <= fill + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_location_speed_estimator.sv
// Bench for location_speed_estimator: sample-level reference model
// plus directed position sequences with literal expectations.
module tb_location_speed_estimator;
    localparam int SD    = 1000;
    localparam int PW    = 17;
    localparam int DW    = 16;
    localparam int AS    = 2;
    localparam int MAXD  = 4096;
    localparam int DEPTH = 1 << AS;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [PW-1:0] pos = '0;
    logic [DW-1:0] speed;
    logic          valid;
    logic          fault;
    logic          ready;

    location_speed_estimator dut (
        .sys_clk                       (sys_clk),
        .reset_n                       (rst),
        .speed_estimate_enable_in      (en),
        .location_detection_value_in   (pos),
        .pmsm_location_speed_value_out (speed),
        .speed_valid_out               (valid),
        .location_jump_fault_out       (fault),
        .speed_ready_out               (ready)
    );

    always #5 sys_clk = ~sys_clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    always @(posedge sys_clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    // Reference model: k counts clock edges since enable was accepted;
    // sample n lands on edge n*SD, its result two edges later.
    int k = -1;
    int prev = 0;
    int due = 0;
    int pdelta = 0;
    bit pend = 1'b0;
    int q[$];
    int e_speed = 0;
    int e_valid = 0;
    int e_fault = 0;
    int e_ready = 0;

    always @(posedge sys_clk or posedge rst) begin
        int s;
        int d;
        e_valid = 0;
        e_fault = 0;
        if (rst || !en) begin
            k = -1;
            pend = 1'b0;
            q.delete();
            e_speed = 0;
            e_ready = 0;
        end else begin
            k = (k < 0) ? 0 : k + 1;
            if (pend && k == due) begin
                pend = 1'b0;
                if (pdelta > MAXD || pdelta < -MAXD) begin
                    e_fault = 1;
                end else begin
                    q.push_back(pdelta);
                    if (q.size() > DEPTH) void'(q.pop_front());
                    s = 0;
                    foreach (q[i]) s += q[i];
                    s = s >>> AS;
                    if (s > (1 << (DW - 1)) - 1) s = (1 << (DW - 1)) - 1;
                    if (s < -(1 << (DW - 1))) s = -(1 << (DW - 1));
                    e_speed = s;
                    e_valid = 1;
                    e_ready = (q.size() == DEPTH) ? 1 : 0;
                end
            end
            if (k > 0 && k % SD == 0) begin
                if (k != SD) begin
                    d = (int'(pos) - prev) & ((1 << PW) - 1);
                    if (d >= (1 << (PW - 1))) d -= (1 << PW);
                    pend = 1'b1;
                    due = k + 2;
                    pdelta = d;
                end
                prev = int'(pos);
            end
        end
    end

    int vlog[$];
    int rlog[$];
    int vcyc[$];
    int fcnt = 0;

    always @(negedge sys_clk) begin
        check("speed", int'($signed(speed)), e_speed);
        check("valid", int'(valid), e_valid);
        check("fault", int'(fault), e_fault);
        check("ready", int'(ready), e_ready);
        if (valid) begin
            vlog.push_back(int'($signed(speed)));
            rlog.push_back(int'(ready));
            vcyc.push_back(cyc);
        end
        if (fault) fcnt++;
    end

    int en_cyc = 0;

    task automatic clear_logs();
        vlog.delete();
        rlog.delete();
        vcyc.delete();
        fcnt = 0;
    endtask

    task automatic run_seq(input int vals[$]);
        clear_logs();
        @(posedge sys_clk); #1;
        pos = PW'(vals[0]);
        en = 1'b1;
        en_cyc = cyc + 1;
        @(posedge sys_clk);
        for (int i = 1; i < vals.size(); i++) begin
            repeat (SD) @(posedge sys_clk);
            #1 pos = PW'(vals[i]);
        end
        repeat (SD + 3) @(posedge sys_clk);
        #1;
    endtask

    task automatic stop_seq();
        en = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_q(input string name, input int act[$],
                            input int exp[$]);
        check({name, "_len"}, act.size(), exp.size());
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            check(name, act[i], exp[i]);
    endtask

    task automatic expect_first(input string name);
        if (vcyc.size() > 0) check(name, vcyc[0] - en_cyc, 2 * SD + 2);
        else check(name, -1, 2 * SD + 2);
    endtask

    int ev[$];
    int er[$];

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_speed", int'(speed), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_ready", int'(ready), 0);
        rst = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;

        run_seq('{1000, 1000, 1000, 1000, 1000, 1000});
        ev = '{0, 0, 0, 0, 0};
        er = '{0, 0, 0, 1, 1};
        expect_q("t1_val", vlog, ev);
        expect_q("t1_rdy", rlog, er);
        expect_first("t1_first");
        check("t1_faults", fcnt, 0);
        stop_seq();

        run_seq('{500, 600, 700, 800, 900, 1000, 1100});
        ev = '{25, 50, 75, 100, 100, 100};
        er = '{0, 0, 0, 1, 1, 1};
        expect_q("t2_val", vlog, ev);
        expect_q("t2_rdy", rlog, er);
        stop_seq();

        run_seq('{130600, 130700, 130800, 130900, 131000, 28, 128});
        ev = '{25, 50, 75, 100, 100, 100};
        expect_q("t3_val", vlog, ev);
        check("t3_faults", fcnt, 0);
        stop_seq();

        run_seq('{131050, 131000, 130950, 130900, 130850});
        ev = '{-13, -25, -38, -50};
        expect_q("t4_val", vlog, ev);
        stop_seq();

        run_seq('{1000, 1100, 1200, 1300, 1400, 21400, 21500, 21600});
        ev = '{25, 50, 75, 100, 100, 100};
        expect_q("t5_val", vlog, ev);
        check("t5_faults", fcnt, 1);
        stop_seq();

        run_seq('{0, 4096, 0, 65536, 69633});
        ev = '{1024, 0};
        expect_q("t5b_val", vlog, ev);
        check("t5b_faults", fcnt, 2);
        stop_seq();

        clear_logs();
        @(posedge sys_clk); #1;
        pos = PW'(5000);
        en = 1'b1;
        @(posedge sys_clk);
        for (int i = 1; i <= 3; i++) begin
            repeat (SD) @(posedge sys_clk);
            #1 pos = PW'(5000 + 100 * i);
        end
        repeat (SD / 2) @(posedge sys_clk);
        #1;
        ev = '{25, 50};
        expect_q("t6_pre", vlog, ev);
        check("t6_mid_speed", int'($signed(speed)), 50);
        rst = 1'b1;
        #1;
        check("t6_rst_speed", int'(speed), 0);
        check("t6_rst_valid", int'(valid), 0);
        check("t6_rst_fault", int'(fault), 0);
        check("t6_rst_ready", int'(ready), 0);
        repeat (3) @(posedge sys_clk);
        #1 rst = 1'b0;
        repeat (SD / 2) @(posedge sys_clk);
        #1 en = 1'b0;
        run_seq('{5300, 5400, 5500, 5600, 5700});
        ev = '{25, 50, 75, 100};
        er = '{0, 0, 0, 1};
        expect_q("t6_val", vlog, ev);
        expect_q("t6_rdy", rlog, er);
        expect_first("t6_first");
        stop_seq();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/location_speed_estimator.md
Name: location_speed_estimator

Overview:
- Consumes the absolute single-turn position from the location control unit, `location_detection_value_out`.
- Differentiates that position at a fixed sample rate, with modulo wrap-around handling, and averages the last 2^AVG_SHIFT deltas.
- Outputs a signed mechanical speed estimate, counts per sample period, to the speed loop and status logic.
- Flags implausible position jumps caused by encoder or SSI glitches and excludes them from the average.

Parameters:
- DATA_WIDTH, 16, width of the signed speed output.
- POS_WIDTH, 17, absolute encoder position width; position modulus is 2^POS_WIDTH.
- SAMPLE_DIV, 1000, sys_clk cycles per speed sample, minimum 4.
- AVG_SHIFT, 2, averaging depth: the window holds 2^AVG_SHIFT deltas.
- MAX_DELTA, 4096, largest accepted |delta| per sample.

Ports:
- sys_clk  input  1  system clock.
- reset_n  input  1  asynchronous reset, active-high (asserted = 1, despite the name).
- speed_estimate_enable_in  input  1  level enable; low means idle and cleared.
- location_detection_value_in  input  POS_WIDTH  absolute position from the location detection path.
- pmsm_location_speed_value_out  output  DATA_WIDTH  signed averaged speed, counts per sample.
- speed_valid_out  output  1  one-cycle pulse when the speed output updates.
- location_jump_fault_out  output  1  one-cycle pulse when a delta is rejected.
- speed_ready_out  output  1  high once the averaging window is full.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state IDLE, sample counter 0, window entries 0, running sum 0, fill count 0.
- States:
  - IDLE: while enable is low; counter and window held cleared.
  - PRIME: enable rises; first tick captures prev_pos only, no delta produced; then go to RUN.
  - RUN: each tick produces one delta.
  - Enable low in any state: IDLE on the next clock; window, sum, fill and outputs cleared to 0; any pulse in flight is suppressed.
- Sample tick:
  - Counter runs 0..SAMPLE_DIV-1 while enabled; tick is the cycle where the counter equals SAMPLE_DIV-1.
  - Counter restarts at 0 on entry from IDLE.
- Pipeline, with tick at cycle T:
  - T: capture cur_pos.
  - T+1: register delta = (cur_pos - prev_pos) mod 2^POS_WIDTH, interpreted as a signed POS_WIDTH value (range -2^(POS_WIDTH-1) .. 2^(POS_WIDTH-1)-1); set prev_pos = cur_pos.
  - T+2: update window and sum, register the output, pulse speed_valid_out.
- Jump check:
  - |delta| > MAX_DELTA: at T+2 pulse location_jump_fault_out instead of speed_valid_out.
  - The window, sum, fill count and output are unchanged for a rejected delta.
  - prev_pos is still updated, so recovery happens on the next sample.
- Window:
  - Circular buffer of 2^AVG_SHIFT deltas.
  - On accept: sum += new - oldest; oldest slot is overwritten; write index wraps.
  - Sum width is POS_WIDTH + AVG_SHIFT, signed.
  - Fill count saturates at 2^AVG_SHIFT; speed_ready_out = 1 when full.
- Output:
  - Value is sum >>> AVG_SHIFT (arithmetic shift, rounds toward -inf), saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - speed_valid_out pulses on every accepted delta, including before the window is full; zeros in unfilled slots give a partial average.
  - Output holds between pulses.
- Simultaneous events:
  - Reset dominates everything.
  - Enable dropping on a tick cycle: the tick is ignored.
- Delta = exactly ±MAX_DELTA is accepted.
- Delta = -2^(POS_WIDTH-1) (half-turn jump) is always a fault when MAX_DELTA < 2^(POS_WIDTH-1).

Test Plan:
1. Defaults, enable = 1, position held at 1000 → first valid pulse at the second tick + 2 cycles with output 0; valid every 1000 cycles; speed_ready_out high after the 5th tick.
2. Position +100 per sample from 500 → outputs 25, 50, 75, 100, 100…; speed_ready_out rises with the 4th valid pulse.
3. Wrap-around, prev = 131000 then cur = 28, after 4 equal steps → delta +100, output 100, no fault.
4. Position -50 per sample, 131050 → 131000 → … → outputs -13, -25, -38, -50 (floor).
5. Steady +100, then one sample jumps +20000, then +100 resumes → one location_jump_fault_out pulse, no valid on that sample, output stays 100; next valid is 100.
6. Reset asserted mid-RUN, then enable toggled low for 1 cycle → all outputs 0 immediately on reset; after enable returns, PRIME is repeated (no valid on the first tick), fill restarts from 0.
